// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with per-key debounce.
//   Drives one column low at a time, samples the synchronized rows once per
//   scan slot, debounces a single pressed key and reports its hex code.
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, exactly one bit low
//   key[3:0]   hex code of the last accepted key
//   key_valid  one-cycle pulse when a new key is accepted
//   key_held   high while the accepted key remains pressed
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DEB_CNT  = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEB_CNT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [3:0]        row_meta, rs;
  logic [SLOT_W-1:0] slot;
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc_c;
  logic [3:0]        cand, cand_d;
  logic [3:0]        col_d, key_d, col_rot_c;
  logic              key_valid_d, key_held_d;
  logic              sample_c, none_c, single_c, match_c;
  logic [1:0]        row_idx_c, col_idx_c;
  logic [3:0]        code_c;

  // Row/column position to hex legend
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  // Two-flop row synchronizer, idles at all-ones (no key)
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  // Scan slot counter; the last slot cycle is the sample point
  assign sample_c = (slot == SLOT_LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) slot <= '0;
    else      slot <= sample_c ? '0 : slot + SLOT_W'(1);
  end

  // Sample classification and key code of the active column
  always_comb begin
    none_c    = (rs == 4'hF);
    single_c  = 1'b0;
    row_idx_c = 2'd0;
    case (rs)
      4'b1110: begin single_c = 1'b1; row_idx_c = 2'd0; end
      4'b1101: begin single_c = 1'b1; row_idx_c = 2'd1; end
      4'b1011: begin single_c = 1'b1; row_idx_c = 2'd2; end
      4'b0111: begin single_c = 1'b1; row_idx_c = 2'd3; end
      default: ;
    endcase
    col_idx_c = 2'd0;
    case (col)
      4'b1101: col_idx_c = 2'd1;
      4'b1011: col_idx_c = 2'd2;
      4'b0111: col_idx_c = 2'd3;
      default: col_idx_c = 2'd0;
    endcase
  end

  assign code_c    = key_map(row_idx_c, col_idx_c);
  assign match_c   = single_c && (code_c == cand);
  assign cnt_inc_c = cnt + CNT_ONE;
  assign col_rot_c = {col[2:0], col[3]};

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_SCAN;
    else      state <= state_d;
  end

  // Next-state logic, evaluated only on sample cycles
  always_comb begin
    state_d = state;
    if (sample_c) begin
      case (state)
        S_SCAN:     if (single_c) state_d = S_DEBOUNCE;
        S_DEBOUNCE: begin
          if (!match_c)                    state_d = S_SCAN;
          else if (cnt_inc_c == CNT_DONE)  state_d = S_HELD;
        end
        S_HELD:     if (none_c) state_d = S_RELEASE;
        S_RELEASE: begin
          if (!none_c)                     state_d = S_HELD;
          else if (cnt_inc_c == CNT_DONE)  state_d = S_SCAN;
        end
        default:    state_d = S_SCAN;
      endcase
    end
  end

  // Output/datapath next values; col only moves when leaving or skipping a column
  always_comb begin
    col_d       = col;
    key_d       = key;
    cand_d      = cand;
    cnt_d       = cnt;
    key_valid_d = 1'b0;
    key_held_d  = (state_d == S_HELD) || (state_d == S_RELEASE);
    if (sample_c) begin
      case (state)
        S_SCAN: begin
          if (single_c) begin
            cand_d = code_c;
            cnt_d  = CNT_ONE;
          end else begin
            col_d  = col_rot_c;
          end
        end
        S_DEBOUNCE: begin
          if (!match_c) begin
            cnt_d = '0;
            col_d = col_rot_c;
          end else if (cnt_inc_c == CNT_DONE) begin
            cnt_d       = '0;
            key_d       = cand;
            key_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        S_HELD: begin
          if (none_c) cnt_d = CNT_ONE;
        end
        S_RELEASE: begin
          if (!none_c) begin
            cnt_d = '0;
          end else if (cnt_inc_c == CNT_DONE) begin
            cnt_d = '0;
            col_d = col_rot_c;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      col       <= 4'b1110;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      cand      <= 4'h0;
      cnt       <= '0;
    end else begin
      col       <= col_d;
      key       <= key_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
      cand      <= cand_d;
      cnt       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed + randomized bench for keypad_scan with a
// sample-level reference model of the scanner and a 4x4 switch-matrix keypad.
module tb_keypad_scan;

  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int LAT = (DEB - 1) * DIV + 1;

  localparam int MD_SCAN = 0;
  localparam int MD_DEB  = 1;
  localparam int MD_HELD = 2;
  localparam int MD_REL  = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] row = 4'hF;
  logic [3:0] col, key;
  logic       key_valid, key_held;

  keypad_scan #(.SCAN_DIV(DIV), .DEB_CNT(DEB)) dut (
    .clk(clk), .clr(clr), .row(row), .col(col),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int pulses = 0;

  bit pressed [4][4];
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  // Reference model state
  int         m_slot, m_ci, m_mode, m_cnt, m_detect_edge;
  logic [3:0] m_s1, m_rs, m_cand, m_key;
  logic       m_kv;

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edges);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edges);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_ci = 0; m_mode = MD_SCAN; m_cnt = 0;
    m_s1 = 4'hF; m_rs = 4'hF; m_cand = 4'h0; m_key = 4'h0; m_kv = 1'b0;
  endtask

  // One clock edge of the scanner as described by its rules
  task automatic model_edge();
    int nlow, r_i;
    logic [3:0] code;
    edges++;
    if (clr == 1'b0) begin
      model_reset();
      return;
    end
    m_kv = 1'b0;
    if (m_slot == DIV - 1) begin
      nlow = 0; r_i = 0;
      for (int i = 0; i < 4; i++) if (m_rs[i] == 1'b0) begin nlow++; r_i = i; end
      code = keymap[r_i * 4 + m_ci];
      case (m_mode)
        MD_SCAN:
          if (nlow == 1) begin
            m_cand = code; m_cnt = 1; m_mode = MD_DEB; m_detect_edge = edges;
          end else m_ci = (m_ci + 1) % 4;
        MD_DEB:
          if (nlow == 1 && code == m_cand) begin
            m_cnt++;
            if (m_cnt == DEB) begin m_key = m_cand; m_kv = 1'b1; m_mode = MD_HELD; end
          end else begin
            m_cnt = 0; m_mode = MD_SCAN; m_ci = (m_ci + 1) % 4;
          end
        MD_HELD:
          if (nlow == 0) begin m_cnt = 1; m_mode = MD_REL; end
        default:
          if (nlow == 0) begin
            m_cnt++;
            if (m_cnt == DEB) begin m_mode = MD_SCAN; m_ci = (m_ci + 1) % 4; end
          end else begin
            m_cnt = 0; m_mode = MD_HELD;
          end
      endcase
    end
    m_slot = (m_slot + 1) % DIV;
    m_rs = m_s1;
    m_s1 = row;
  endtask

  // Switch matrix: a pressed key pulls its row low while its column is driven
  task automatic drive_rows();
    logic [3:0] rv;
    rv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && col[c] === 1'b0) rv[r] = 1'b0;
    row = rv;
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
  endtask

  task automatic check_outputs();
    logic [3:0] ec;
    ec = ~(4'b0001 << m_ci);
    check4("col", col, ec);
    check4("key", key, m_key);
    check4("key_valid", {3'b000, key_valid}, {3'b000, m_kv});
    check4("key_held", {3'b000, key_held},
           {3'b000, (m_mode == MD_HELD || m_mode == MD_REL)});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive_rows();
    check_outputs();
    if (key_valid === 1'b1) begin
      pulses++;
      check_int("press_latency", edges - m_detect_edge + 1, LAT);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int p0, rr, cc, rr2, cc2, n;

  initial begin
    release_all();
    model_reset();
    m_detect_edge = 0;

    // Asynchronous reset takes effect without a clock edge
    #1 clr = 1'b0;
    #1;
    model_reset();
    check_outputs();
    drive_rows();
    run(3);
    #2 clr = 1'b1;

    // Idle rows: column rotation only, no pulse
    p0 = pulses;
    run(64);
    check_int("idle_pulses", pulses - p0, 0);

    // Key "6" held, then released
    p0 = pulses;
    pressed[1][2] = 1'b1;
    run(48);
    check_int("key6_pulses", pulses - p0, 1);
    check4("key6_code", key, 4'h6);
    check4("key6_held", {3'b000, key_held}, 4'h1);
    release_all();
    run(40);
    check4("key6_released", {3'b000, key_held}, 4'h0);
    check4("key6_kept", key, 4'h6);

    // Random single key
    rr = $urandom_range(3, 0);
    cc = $urandom_range(3, 0);
    p0 = pulses;
    pressed[rr][cc] = 1'b1;
    run(48);
    check_int("rand_key_pulses", pulses - p0, 1);
    check4("rand_key_code", key, keymap[rr * 4 + cc]);
    release_all();
    run(40);

    // Bounce on "1": one sample low, one sample high, then stable
    n = 0;
    while (!(m_mode == MD_SCAN && m_ci == 3 && m_slot == 0) && n < 64) begin step(); n++; end
    check_int("bounce_align", (n < 64) ? 1 : 0, 1);
    p0 = pulses;
    pressed[0][0] = 1'b1;
    run(DIV + 2);
    pressed[0][0] = 1'b0;
    run(DIV);
    check_int("bounce_no_pulse", pulses - p0, 0);
    pressed[0][0] = 1'b1;
    run(60);
    check_int("bounce_pulses", pulses - p0, 1);
    check4("bounce_code", key, 4'h1);
    release_all();
    run(40);

    // Two rows on one column: no acceptance until one is released
    p0 = pulses;
    pressed[0][2] = 1'b1;
    pressed[1][2] = 1'b1;
    run(48);
    check_int("multi_pulses", pulses - p0, 0);
    pressed[0][2] = 1'b0;
    run(48);
    check_int("multi_then_single", pulses - p0, 1);
    check4("multi_code", key, 4'h6);
    release_all();
    run(40);

    // "0" held, "A" added while held, then "A" alone
    p0 = pulses;
    pressed[3][0] = 1'b1;
    run(48);
    pressed[0][3] = 1'b1;
    run(40);
    check_int("second_key_pulses", pulses - p0, 1);
    check4("second_key_code", key, 4'h0);
    release_all();
    run(40);
    check4("both_released", {3'b000, key_held}, 4'h0);
    pressed[0][3] = 1'b1;
    run(48);
    check_int("keyA_pulses", pulses - p0, 2);
    check4("keyA_code", key, 4'hA);
    release_all();
    run(40);

    // Reset during debounce of "D"
    p0 = pulses;
    pressed[3][3] = 1'b1;
    n = 0;
    while (m_mode != MD_DEB && n < 64) begin step(); n++; end
    check_int("reach_debounce", (n < 64) ? 1 : 0, 1);
    #2 clr = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check4("reset_col", col, 4'b1110);
    release_all();
    drive_rows();
    run(3);
    #2 clr = 1'b1;
    run(2);
    check4("resume_col", col, 4'b1110);
    run(40);
    check_int("reset_no_pulse", pulses - p0, 0);

    // Randomized press/release soak against the model
    for (int t = 0; t < 8; t++) begin
      rr = $urandom_range(3, 0);  cc = $urandom_range(3, 0);
      pressed[rr][cc] = 1'b1;
      if ($urandom_range(1, 0) == 1) begin
        rr2 = $urandom_range(3, 0);  cc2 = $urandom_range(3, 0);
        pressed[rr2][cc2] = 1'b1;
      end
      run($urandom_range(60, 8));
      release_all();
      run($urandom_range(40, 6));
    end
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000; clk cycles each column is driven before its rows are sampled (range 4..2^20).
REQ-002 Parameter DEB_CNT, default 4; consecutive identical samples needed to accept a press or a release (range 2..15).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous and active-low.
REQ-005 row  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
REQ-006 col  output  4  keypad column drive; exactly one bit low, all others high.
REQ-007 key  output  4  hex code of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-011 A slot counter SHALL count 0..SCAN_DIV-1 and wrap; a "sample" occurs in the cycle when slot = SCAN_DIV-1.
REQ-012 Key map, row r (rs[r] low) / column c (col[c] low): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D (c = 0..3 left to right).
REQ-013 A sample is "single" when exactly one rs bit is low, "none" when rs = 4'hF, and "multi" otherwise.
REQ-014 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: on a none or multi sample, col SHALL rotate to the next column (1110->1101->1011->0111->1110) on the sample cycle.
REQ-016 SCAN: on a single sample, col SHALL freeze, the candidate code SHALL be latched, match count SHALL be set to 1, and the FSM SHALL go to DEBOUNCE.
REQ-017 DEBOUNCE: a sample equal to the candidate SHALL increment the count; on reaching DEB_CNT, key SHALL load the candidate and key_valid SHALL pulse in the next cycle, and the FSM SHALL go to HELD.
REQ-018 DEBOUNCE: a none, multi, or different-row sample SHALL clear the count, return the FSM to SCAN, and advance col; no pulse SHALL be issued.
REQ-019 HELD: key_held = 1; col stays frozen; a none sample SHALL set the release count to 1 and move to RELEASE; single and multi samples SHALL be ignored.
REQ-020 RELEASE: key_held stays 1; a none sample SHALL increment the count, and on reaching DEB_CNT the FSM SHALL go to SCAN with key_held = 0 and col advanced; any non-none sample SHALL return the FSM to HELD with the count cleared.
REQ-021 key_valid SHALL pulse exactly once per accepted press, and never while held, during release, or on a second key pressed while one is held.
REQ-022 key SHALL hold its value until the next accepted press; it SHALL NOT change on release.
REQ-023 Press latency: key_valid SHALL rise (DEB_CNT-1)*SCAN_DIV+1 cycles after the sample cycle that first detected the key.

Reset
REQ-024 While clr = 0, col = 4'b1110, key = 4'h0, key_valid = 0, key_held = 0, FSM = SCAN, and all counters and synchronizer flops = 0 or all-ones (row idle); this state SHALL take effect asynchronously.
REQ-025 Assertion of clr mid-debounce or mid-hold SHALL discard the candidate with no pulse; after release, scanning SHALL restart from column 0.

Verification (SCAN_DIV=4, DEB_CNT=3)
REQ-026 Reset, then idle rows 4'hF for 64 cycles -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never high.
REQ-027 Hold row[1] low whenever col = 1011 (key "6") for 40 cycles -> exactly one key_valid pulse 9 cycles after the detection sample; key = 4'h6; key_held = 1 until 3 none samples after release.
REQ-028 Bounce: row[0] low on col 1110 for 1 sample, then high for 1 sample, then stable low -> no pulse on the bounce; a single pulse with key = 4'h1 after the stable press.
REQ-029 Two rows low simultaneously on one column -> multi, scanning continues, no pulse; releasing one row -> normal acceptance of the remaining key.
REQ-030 Hold "0" (r3, c0), then also press "A" while held -> one pulse only, key stays 4'h0; release both -> key_held drops; press "A" alone -> pulse with key = 4'hA.
REQ-031 Drive clr low during DEBOUNCE of key "D" -> outputs reach reset values immediately; no pulse; scanning resumes at col 1110 after clr is released.
